// File: rtl/rom_arb_pkg.sv
// Shared constants, state encoding and pipeline tag type for the ROM read arbiter.
package rom_arb_pkg;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 3;
    localparam int ID_W   = 1;

    // FSM state encoding
    localparam logic ST_IDLE_ENC  = 1'b0;
    localparam logic ST_ISSUE_ENC = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE_ENC,
        ISSUE = ST_ISSUE_ENC
    } state_e;

    // Field offsets inside the flattened per-requester request buses
    localparam int REQ0_ADDR_LSB = 0;
    localparam int REQ1_ADDR_LSB = ADDR_W;
    localparam int REQ0_LEN_LSB  = 0;
    localparam int REQ1_LEN_LSB  = LEN_W;

    // Tag that travels alongside each ROM read until its byte is captured
    typedef struct packed {
        logic valid;
        logic id;
        logic last;
    } tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a
// tie; after every grant it moves to the requester that did not win.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] grant_o,
    output logic       ptr_o
);

    logic ptr_q;
    logic ptr_d;

    // One-hot grant; a lone requester wins regardless of the pointer
    always_comb begin
        grant_o = 2'b00;
        ptr_d   = ptr_q;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
        if (adv_i && (grant_o != 2'b00)) begin
            ptr_d = ~grant_o[1];
        end
    end

    // Priority pointer register, starts at requester 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares the byte-addressed ROM between two burst-read requesters. A granted
// burst drives one ROM address per cycle; a two-stage tag pipeline follows
// the one-cycle ROM latency and returns each byte tagged with its owner.
module rom_read_arbiter
    import rom_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*LEN_W-1:0]  req_len_m1,
    output logic [NREQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [DATA_W-1:0]      rom_dout,
    output logic                   rsp_valid,
    output logic                   rsp_id,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_last,
    output logic                   busy
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   curAddr_q, curAddr_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic                curId_q, curId_d;

    tag_t                s1Tag_q;
    logic                rspValid_q;
    logic                rspId_q;
    logic [DATA_W-1:0]   rspData_q;
    logic                rspLast_q;

    logic [NREQ-1:0]     arbReq;
    logic [NREQ-1:0]     arbGrant;
    logic                arbPtr;
    logic                advEn;
    logic                grantId;
    logic [NREQ-1:0]     readyRaw;

    // Arbitration only happens in IDLE, so requests are hidden elsewhere
    assign arbReq = (state_q == IDLE) ? req_valid : '0;
    assign advEn  = (state_q == IDLE);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (arbReq),
        .adv_i   (advEn),
        .grant_o (arbGrant),
        .ptr_o   (arbPtr)
    );

    // Field-mux select: the same winner the arbiter picks, taken from the
    // pointer on a tie so the mux select does not wait on the one-hot grant
    assign grantId = (req_valid == 2'b11) ? arbPtr : req_valid[1];

    // Next-state logic: accept a burst in IDLE, walk its addresses in ISSUE
    always_comb begin
        state_d     = state_q;
        curAddr_d   = curAddr_q;
        remaining_d = remaining_q;
        curId_d     = curId_q;
        readyRaw    = '0;
        unique case (state_q)
            IDLE: begin
                if (req_valid != '0) begin
                    readyRaw    = arbGrant;
                    curId_d     = grantId;
                    curAddr_d   = grantId ? req_addr[REQ1_ADDR_LSB +: ADDR_W]
                                          : req_addr[REQ0_ADDR_LSB +: ADDR_W];
                    remaining_d = grantId ? req_len_m1[REQ1_LEN_LSB +: LEN_W]
                                          : req_len_m1[REQ0_LEN_LSB +: LEN_W];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (remaining_q == '0) begin
                    state_d = IDLE;
                end else begin
                    curAddr_d   = curAddr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and burst-address registers; the address holds after the last byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            curAddr_q   <= '0;
            remaining_q <= '0;
            curId_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            curAddr_q   <= curAddr_d;
            remaining_q <= remaining_d;
            curId_q     <= curId_d;
        end
    end

    // Response pipeline: stage 1 tag lines up with rom_dout, stage 2 captures it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Tag_q    <= '0;
            rspValid_q <= 1'b0;
            rspId_q    <= 1'b0;
            rspData_q  <= '0;
            rspLast_q  <= 1'b0;
        end else begin
            s1Tag_q    <= {(state_q == ISSUE), curId_q, (remaining_q == '0)};
            rspValid_q <= s1Tag_q.valid;
            rspId_q    <= s1Tag_q.id;
            rspData_q  <= rom_dout;
            rspLast_q  <= s1Tag_q.last;
        end
    end

    // Accept strobe is forced low while reset is asserted
    assign req_ready = readyRaw & {NREQ{rst_n}};
    assign rom_addr  = curAddr_q;
    assign rsp_valid = rspValid_q;
    assign rsp_id    = rspId_q;
    assign rsp_data  = rspData_q;
    assign rsp_last  = rspLast_q;
    assign busy      = (state_q == ISSUE) | s1Tag_q.valid | rspValid_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed testbench for rom_read_arbiter with a behavioural ROM model.
module tb_rom_read_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [11:0] req_addr;
    logic [5:0]  req_len_m1;
    logic [1:0]  req_ready;
    logic [5:0]  rom_addr;
    logic [7:0]  rom_dout;
    logic        rsp_valid;
    logic        rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_last;
    logic        busy;

    int passCount  = 0;
    int failCount  = 0;
    int totalCount = 0;

    rom_read_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_len_m1 (req_len_m1),
        .req_ready  (req_ready),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM contents: the bytes named in the test plan, a simple pattern elsewhere
    function automatic logic [7:0] romByte(input logic [5:0] a);
        case (a)
            6'd0:    romByte = 8'hFF;
            6'd1:    romByte = 8'h80;
            6'd2:    romByte = 8'h6C;
            6'd8:    romByte = 8'h80;
            6'd62:   romByte = 8'h1E;
            6'd63:   romByte = 8'h19;
            default: romByte = {2'b00, a} ^ 8'h5A;
        endcase
    endfunction

    // One-cycle registered ROM read
    always @(posedge clk) begin
        rom_dout <= romByte(rom_addr);
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [5:0] a1, input logic [5:0] a0,
                                 input logic [2:0] l1, input logic [2:0] l0);
        req_valid  = valid;
        req_addr   = {a1, a0};
        req_len_m1 = {l1, l0};
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkRsp(input string tag, input int v, input int id, input int data, input int last);
        checkOutput({tag, "_valid"}, 32'(rsp_valid), v);
        if (v != 0) begin
            checkOutput({tag, "_id"},   32'(rsp_id),   id);
            checkOutput({tag, "_data"}, 32'(rsp_data), data);
            checkOutput({tag, "_last"}, 32'(rsp_last), last);
        end
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        applyStimulus(2'b00, 6'd0, 6'd0, 3'd0, 3'd0);
        #1;
        checkOutput("rst_rom_addr",  32'(rom_addr),  0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rst_rsp_id",    32'(rsp_id),    0);
        checkOutput("rst_rsp_data",  32'(rsp_data),  0);
        checkOutput("rst_rsp_last",  32'(rsp_last),  0);
        checkOutput("rst_busy",      32'(busy),      0);
        checkOutput("rst_req_ready", 32'(req_ready), 0);

        // Contention: both valid while still in reset
        nextCycle();
        applyStimulus(2'b11, 6'd63, 6'd8, 3'd0, 3'd0);
        #1;
        checkOutput("ready_in_reset", 32'(req_ready), 0);
        nextCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("contend_first", 32'(req_ready), 'h1);
        nextCycle();
        req_valid = 2'b10;
        #1;
        checkOutput("ready_in_issue", 32'(req_ready), 0);
        checkOutput("contend_addr0", 32'(rom_addr), 8);
        checkOutput("contend_busy", 32'(busy), 1);
        nextCycle();
        checkOutput("contend_second", 32'(req_ready), 'h2);
        nextCycle();
        req_valid = 2'b00;
        #1;
        checkRsp("contend_rsp0", 1, 0, 'h80, 1);
        checkOutput("contend_addr1", 32'(rom_addr), 63);
        nextCycle();
        checkRsp("contend_gap", 0, 0, 0, 0);
        nextCycle();
        checkRsp("contend_rsp1", 1, 1, 'h19, 1);
        applyStimulus(2'b11, 6'd10, 6'd9, 3'd0, 3'd0);
        #1;
        checkOutput("rr_after_req1", 32'(req_ready), 'h1);
        nextCycle();
        req_valid = 2'b10;
        nextCycle();
        checkOutput("rr_then_req1", 32'(req_ready), 'h2);
        nextCycle();
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) nextCycle();

        // Single burst from address 0
        applyStimulus(2'b01, 6'd0, 6'd0, 3'd0, 3'd2);
        #1;
        checkOutput("single_ready", 32'(req_ready), 'h1);
        nextCycle();
        req_valid = 2'b00;
        checkOutput("single_addr0", 32'(rom_addr), 0);
        nextCycle();
        checkOutput("single_addr1", 32'(rom_addr), 1);
        nextCycle();
        checkOutput("single_addr2", 32'(rom_addr), 2);
        checkRsp("single_b0", 1, 0, 'hFF, 0);
        nextCycle();
        checkRsp("single_b1", 1, 0, 'h80, 0);
        nextCycle();
        checkRsp("single_b2", 1, 0, 'h6C, 1);
        nextCycle();
        checkRsp("single_end", 0, 0, 0, 0);
        checkOutput("single_busy_end", 32'(busy), 0);

        // Wrap-around burst from requester 1
        nextCycle();
        applyStimulus(2'b10, 6'd62, 6'd0, 3'd3, 3'd0);
        #1;
        checkOutput("wrap_ready", 32'(req_ready), 'h2);
        nextCycle();
        req_valid = 2'b00;
        checkOutput("wrap_addr62", 32'(rom_addr), 62);
        nextCycle();
        checkOutput("wrap_addr63", 32'(rom_addr), 63);
        nextCycle();
        checkOutput("wrap_addr0", 32'(rom_addr), 0);
        checkRsp("wrap_b0", 1, 1, 'h1E, 0);
        nextCycle();
        checkOutput("wrap_addr1", 32'(rom_addr), 1);
        checkRsp("wrap_b1", 1, 1, 'h19, 0);
        nextCycle();
        checkRsp("wrap_b2", 1, 1, 'hFF, 0);
        nextCycle();
        checkRsp("wrap_b3", 1, 1, 'h80, 1);
        nextCycle();
        checkRsp("wrap_end", 0, 0, 0, 0);

        // Back-to-back 8-byte bursts from requester 0
        nextCycle();
        applyStimulus(2'b01, 6'd0, 6'd16, 3'd0, 3'd7);
        #1;
        checkOutput("b2b_ready0", 32'(req_ready), 'h1);
        for (int i = 1; i <= 20; i++) begin
            nextCycle();
            if (i == 1) req_addr[5:0] = 6'd24;
            if (i == 10) req_valid = 2'b00;
            #1;
            checkOutput($sformatf("b2b_ready_c%0d", i), 32'(req_ready), (i == 9) ? 'h1 : 'h0);
            if (i >= 3 && i <= 10)
                checkRsp($sformatf("b2b_c%0d", i), 1, 0, 32'(romByte(6'(16 + i - 3))), (i == 10) ? 1 : 0);
            else if (i >= 12 && i <= 19)
                checkRsp($sformatf("b2b_c%0d", i), 1, 0, 32'(romByte(6'(24 + i - 12))), (i == 19) ? 1 : 0);
            else
                checkRsp($sformatf("b2b_c%0d", i), 0, 0, 0, 0);
        end

        // Single-byte burst and busy window
        nextCycle();
        applyStimulus(2'b10, 6'd5, 6'd0, 3'd0, 3'd0);
        #1;
        checkOutput("one_ready", 32'(req_ready), 'h2);
        checkOutput("one_busy_a0", 32'(busy), 0);
        nextCycle();
        req_valid = 2'b00;
        checkOutput("one_busy_a1", 32'(busy), 1);
        nextCycle();
        checkOutput("one_busy_a2", 32'(busy), 1);
        nextCycle();
        checkOutput("one_busy_a3", 32'(busy), 1);
        checkRsp("one_b0", 1, 1, 32'(romByte(6'd5)), 1);
        nextCycle();
        checkOutput("one_busy_a4", 32'(busy), 0);
        checkRsp("one_end", 0, 0, 0, 0);

        // Reset during the 4th issue cycle of an 8-byte burst
        nextCycle();
        applyStimulus(2'b01, 6'd0, 6'd32, 3'd0, 3'd7);
        #1;
        checkOutput("mid_ready", 32'(req_ready), 'h1);
        nextCycle();
        req_valid = 2'b00;
        nextCycle();
        nextCycle();
        checkRsp("mid_b0", 1, 0, 32'(romByte(6'd32)), 0);
        nextCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("mid_busy", 32'(busy), 0);
        checkOutput("mid_rom_addr", 32'(rom_addr), 0);
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("post_rst_valid_%0d", i), 32'(rsp_valid), 0);
            checkOutput($sformatf("post_rst_busy_%0d", i), 32'(busy), 0);
            nextCycle();
        end
        applyStimulus(2'b11, 6'd0, 6'd2, 3'd0, 3'd0);
        #1;
        checkOutput("post_rst_rr", 32'(req_ready), 'h1);
        nextCycle();
        req_valid = 2'b00;
        nextCycle();
        nextCycle();
        checkRsp("post_rst_b0", 1, 0, 'h6C, 1);
        nextCycle();
        checkRsp("post_rst_end", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
